// File: rtl/tmr_pkg.sv
// Shared encodings and helpers for the TMR fault injector and its LFSR source.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_FLIP = 2'b01,
        MODE_SA0  = 2'b10,
        MODE_SA1  = 2'b11
    } fault_mode_e;

    typedef enum logic [1:0] {
        LANE_NONE = 2'b00,
        LANE_A    = 2'b01,
        LANE_B    = 2'b10,
        LANE_C    = 2'b11
    } fault_lane_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_FAULT = 2'b10
    } inj_state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of the state register.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

    function automatic logic apply_fault(input logic s, input fault_mode_e mode);
        logic r;
        case (mode)
            MODE_FLIP: r = ~s;
            MODE_SA0:  r = 1'b0;
            MODE_SA1:  r = 1'b1;
            default:   r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmr_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; never reaches the all-zero state.
module tmr_lfsr8
    import tmr_pkg::*;
(
    input  logic clock,
    input  logic reset,
    output logic bit_o
);

    logic [7:0] state_q;

    // State register: reloads the seed on reset, otherwise advances every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign bit_o = state_q[0];

endmodule

// File: rtl/tmr_fault_injector.sv
// Drives three redundant lanes with one bit stream and corrupts a single lane
// on command after DELAY cycles, either for SEU_LEN cycles (flip) or until released (stuck).
module tmr_fault_injector
    import tmr_pkg::*;
#(
    parameter logic [3:0] DELAY   = 4'd4,
    parameter logic [3:0] SEU_LEN = 4'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    input  logic       src_sel,
    input  logic       inject,
    input  logic [1:0] fault_lane,
    input  logic [1:0] fault_mode,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       fault_active,
    output logic [3:0] fault_count
);

    inj_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    fault_lane_e lane_q, lane_d;
    fault_mode_e mode_q, mode_d;
    logic [3:0]  count_q, count_d;
    logic        a_q, b_q, c_q;
    logic        a_d, b_d, c_d;
    logic        busy_q, active_q;
    logic        lfsr_bit_s;
    logic        src_s;

    tmr_lfsr8 u_lfsr (
        .clock (clock),
        .reset (reset),
        .bit_o (lfsr_bit_s)
    );

    assign src_s = src_sel ? lfsr_bit_s : data_in;

    // Next-state logic for the arm/fault sequencer, delay counter and fault tally.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        mode_d  = mode_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (inject && (fault_lane != LANE_NONE) && (fault_mode != MODE_OFF)) begin
                    lane_d  = fault_lane_e'(fault_lane);
                    mode_d  = fault_mode_e'(fault_mode);
                    cnt_d   = DELAY;
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_FAULT;
                    cnt_d   = (mode_q == MODE_FLIP) ? SEU_LEN : 4'd0;
                    count_d = (count_q != 4'd15) ? (count_q + 4'd1) : count_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FAULT: begin
                if (mode_q == MODE_FLIP) begin
                    if (cnt_q == 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (inject) begin
                    // Releasing inject is consumed; re-arming needs a fresh sample in IDLE.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Lane overlay keyed on the next state so corruption lines up with fault_active.
    always_comb begin
        a_d = src_s;
        b_d = src_s;
        c_d = src_s;
        if (state_d == ST_FAULT) begin
            case (lane_q)
                LANE_A:  a_d = apply_fault(src_s, mode_q);
                LANE_B:  b_d = apply_fault(src_s, mode_q);
                LANE_C:  c_d = apply_fault(src_s, mode_q);
                default: a_d = src_s;
            endcase
        end else begin
            a_d = src_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            lane_q   <= LANE_NONE;
            mode_q   <= MODE_OFF;
            count_q  <= 4'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            busy_q   <= (state_d != ST_IDLE);
            active_q <= (state_d == ST_FAULT);
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign c_out        = c_q;
    assign busy         = busy_q;
    assign fault_active = active_q;
    assign fault_count  = count_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Randomized self-checking bench for tmr_fault_injector using an event-timed reference model.
module tb_tmr_fault_injector;

    localparam int D = 4;
    localparam int L = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic       src_sel = 1'b0;
    logic       inject = 1'b0;
    logic [1:0] fault_lane = 2'b00;
    logic [1:0] fault_mode = 2'b00;
    logic       a_out, b_out, c_out, busy, fault_active;
    logic [3:0] fault_count;

    tmr_fault_injector #(.DELAY(4'd4), .SEU_LEN(4'd1)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .src_sel      (src_sel),
        .inject       (inject),
        .fault_lane   (fault_lane),
        .fault_mode   (fault_mode),
        .a_out        (a_out),
        .b_out        (b_out),
        .c_out        (c_out),
        .busy         (busy),
        .fault_active (fault_active),
        .fault_count  (fault_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: source sequence table plus fault window expressed as edge numbers.
    int         seq [0:254];
    int         pos = 0;
    int         n = 0;
    int         m_arm = -1;
    int         m_lane = 0;
    int         m_mode = 0;
    int         m_cnt = 0;
    logic [2:0] m_l = 3'b000;
    logic       m_fa = 1'b0;

    task automatic build_seq();
        int x [0:262];
        for (int i = 0; i < 7; i++) x[i] = 0;
        x[7] = 1;
        for (int t = 7; t < 262; t++) x[t+1] = x[t-7] ^ x[t-5] ^ x[t-4] ^ x[t-3];
        for (int i = 0; i < 255; i++) seq[i] = x[i+7];
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] c;
        c = m_cnt[3:0];
        return {m_l[2], m_l[1], m_l[0], (m_arm >= 0), m_fa, c};
    endfunction

    function automatic logic [8:0] got_vec();
        return {a_out, b_out, c_out, busy, fault_active, fault_count};
    endfunction

    // Advance model by one edge using the currently driven inputs, then let the DUT take the edge.
    task automatic tick();
        int  s;
        bit  was_armed;
        int  start;
        n++;
        if (reset) begin
            pos = 0; m_arm = -1; m_cnt = 0; m_l = 3'b000; m_fa = 1'b0;
        end else begin
            s = src_sel ? seq[pos] : int'(data_in);
            pos = (pos + 1) % 255;
            was_armed = (m_arm >= 0);
            if (was_armed) begin
                start = m_arm + D;
                if (m_mode == 1 && n == start + L) m_arm = -1;
                else if (m_mode != 1 && n > start && inject) m_arm = -1;
            end
            if (!was_armed && inject && fault_lane != 2'b00 && fault_mode != 2'b00) begin
                m_arm = n; m_lane = int'(fault_lane); m_mode = int'(fault_mode);
            end
            m_fa = (m_arm >= 0) && (n >= m_arm + D);
            if (m_arm >= 0 && n == m_arm + D && m_cnt < 15) m_cnt++;
            m_l = {s[0], s[0], s[0]};
            if (m_fa) begin
                m_l[3 - m_lane] = (m_mode == 1) ? ~s[0] : ((m_mode == 3) ? 1'b1 : 1'b0);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; inject = 1'b0; fault_lane = 2'b00; fault_mode = 2'b00;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (got_vec() !== 9'b000_0_0_0000 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset got=%b exp=%b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_passthrough();
        logic pat [0:3];
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
        src_sel = 1'b0;
        for (int i = 0; i < 24; i++) begin
            data_in = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
            tick();
            total++;
            if (got_vec() !== exp_vec() || a_out !== data_in) begin
                bad++; $display("FAIL passthrough i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flip();
        do_reset();
        src_sel = 1'b0; data_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        inject = 1'b1; fault_lane = 2'b10; fault_mode = 2'b01;
        tick();
        inject = 1'b0; fault_lane = 2'b00; fault_mode = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL flip i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
            if (i == D) begin
                total++;
                if ({a_out, b_out, c_out, fault_active, fault_count} !== 8'b101_1_0001) begin
                    bad++; $display("FAIL flip_window got=%b exp=10110001",
                                    {a_out, b_out, c_out, fault_active, fault_count});
                end
            end
            if (i == D + L) begin
                total++;
                if ({a_out, b_out, c_out, busy} !== 4'b1110) begin
                    bad++; $display("FAIL flip_end got=%b exp=1110", {a_out, b_out, c_out, busy});
                end
            end
        end
    endtask

    task automatic test_stuck();
        do_reset();
        src_sel = 1'b0; data_in = 1'b0;
        tick();
        inject = 1'b1; fault_lane = 2'b01; fault_mode = 2'b11;
        tick();
        inject = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            total++;
            if (got_vec() !== exp_vec() || (i >= D && a_out !== 1'b1)) begin
                bad++; $display("FAIL stuck i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        inject = 1'b1;
        tick();
        inject = 1'b0;
        total++;
        if (got_vec() !== exp_vec() || a_out !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stuck_release got=%b exp=%b", got_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL stuck_after i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ignored();
        do_reset();
        src_sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_in = 1'($urandom_range(0, 1));
            inject = 1'b1;
            fault_lane = (i < 3) ? 2'b00 : 2'($urandom_range(1, 3));
            fault_mode = (i < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick();
            total++;
            if (got_vec() !== exp_vec() || busy !== 1'b0) begin
                bad++; $display("FAIL ignored_noop i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        // Held inject with wandering lane/mode: only the first sample in IDLE counts.
        inject = 1'b1; fault_lane = 2'b11; fault_mode = 2'b01;
        for (int i = 0; i < 16; i++) begin
            data_in = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL ignored_held i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
            fault_lane = 2'($urandom_range(1, 3));
            fault_mode = 2'($urandom_range(1, 3));
            if (i == 0) fault_mode = 2'b01;
        end
        inject = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        src_sel = 1'b0;
        inject = 1'b1; fault_lane = 2'b10; fault_mode = 2'b10;
        tick();
        inject = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_mid got=%b exp=%b", got_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            data_in = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (got_vec() !== exp_vec() || fault_count !== 4'd0 || fault_active !== 1'b0) begin
                bad++; $display("FAIL reset_mid_after i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lfsr_saturate();
        do_reset();
        src_sel = 1'b1;
        for (int i = 0; i < 520; i++) begin
            data_in = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL lfsr i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        for (int f = 0; f < 16; f++) begin
            inject = 1'b1; fault_lane = 2'($urandom_range(1, 3)); fault_mode = 2'b01;
            tick();
            inject = 1'b0;
            for (int i = 0; i < D + L; i++) begin
                tick();
                total++;
                if (got_vec() !== exp_vec()) begin
                    bad++; $display("FAIL sat f=%0d i=%0d got=%b exp=%b", f, i, got_vec(), exp_vec());
                end
            end
        end
        total++;
        if (fault_count !== 4'd15) begin
            bad++; $display("FAIL sat_count got=%0d exp=15", fault_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            inject     = ($urandom_range(0, 5) == 0);
            fault_lane = 2'($urandom_range(0, 3));
            fault_mode = 2'($urandom_range(0, 3));
            data_in    = 1'($urandom_range(0, 1));
            src_sel    = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        reset = 1'b0; inject = 1'b0;
    endtask

    initial begin
        build_seq();
        test_reset();
        test_passthrough();
        test_flip();
        test_stuck();
        test_ignored();
        test_reset_mid();
        test_lfsr_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_fault_injector.md
# tmr_fault_injector

Stimulus-side companion for the 2-of-3 voter: drives three redundant lanes (a, b, c) carrying the same bit stream and corrupts exactly one lane on command with a programmable delay, duration and fault type. It sits in front of the voter under test, either on-chip or in the bench, so single-lane upsets and stuck-at faults can be exercised deterministically. Faults are counted so the result can be checked against the voter's error flag.

## Interface
- DELAY, 4, cycles from accepted inject to first corrupted output; legal 1..15
- SEU_LEN, 1, cycles a flip fault persists; legal 1..15
- clock  input  1  clock, rising edge
- reset  input  1  reset, synchronous, active-high
- data_in  input  1  external source bit
- src_sel  input  1  0: lanes carry data_in; 1: lanes carry internal LFSR bit
- inject  input  1  level, sampled each edge; arms a fault or releases a stuck fault
- fault_lane  input  2  00 none, 01 lane a, 10 lane b, 11 lane c; sampled on accepted inject
- fault_mode  input  2  00 off, 01 flip (SEU), 10 stuck-at-0, 11 stuck-at-1; sampled on accepted inject
- a_out, b_out, c_out  output  1 each  redundant lanes, registered
- busy  output  1  state is ARM or FAULT
- fault_active  output  1  state is FAULT; exactly the cycles in which one lane is corrupted
- fault_count  output  4  faults applied since reset, saturating at 15

## Operation
- Source bit s: data_in when src_sel=0, otherwise bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'h01, advancing every cycle regardless of src_sel. Period is 255 and the state is never 0.
- Every edge: a_out=b_out=c_out=s, except the latched lane while in FAULT:
  - flip: the lane is ~s.
  - stuck-at-0: the lane is 0.
  - stuck-at-1: the lane is 1.
- FSM states: IDLE, ARM, FAULT.
  - IDLE: inject=1 with fault_lane≠00 and fault_mode≠00 latches lane and mode, loads the counter with DELAY, and goes to ARM. Otherwise the inject is a no-op and the state stays IDLE.
  - ARM: the counter decrements each edge. At 1 the state goes to FAULT and, for flip, the counter loads SEU_LEN. inject is ignored.
  - FAULT, flip: the counter decrements. At 1 the state returns to IDLE. inject is ignored.
  - FAULT, stuck: the state holds until inject=1, then goes to IDLE.
- fault_count increments on each ARM→FAULT transition and holds at 15.
- Latched lane and mode do not change outside IDLE, even if the inputs change.
- The inject that releases a stuck fault is consumed. A new fault needs inject sampled again in IDLE, so holding inject high re-arms one cycle after release.

## Timing
- Reset values: a_out=b_out=c_out=0, busy=0, fault_active=0, fault_count=0, state IDLE, LFSR=8'h01, counter=0.
- Reset asserted in any state returns to IDLE at that edge, and any corruption is removed at that edge.
- Source-to-lane latency: 1 cycle, so data_in sampled at edge n appears on the lanes after edge n.
- Inject sampled at edge k:
  - busy=1 after edge k.
  - fault_active=1 and the lane is corrupted after edge k+DELAY.
  - For flip, fault_active falls after edge k+DELAY+SEU_LEN, and busy falls at the same edge.
- Stuck release: inject sampled at edge r in FAULT; the lane is clean and busy=0 after edge r.
- The fault_count increment is visible after the same edge that raises fault_active.

## Structure
- Shared package `tmr_pkg`:
  - fault_mode encodings: MODE_OFF, MODE_FLIP, MODE_SA0, MODE_SA1.
  - fault_lane encodings: LANE_NONE, LANE_A, LANE_B, LANE_C.
  - FSM state enum.
  - LFSR seed and tap constants.
- One sub-module, `tmr_lfsr8`: enable-free 8-bit LFSR with synchronous reset to the seed, output bit 0.
- FSM, counter, fault overlay and fault_count stay in the top module.

## Test plan
- Reset, then src_sel=0 with data_in toggling 0,1,1,0 → the three lanes are identical and follow data_in one cycle late; busy=0, fault_count=0.
- DELAY=4, SEU_LEN=1, lane=10, mode=01, inject at edge 10, data_in=1:
  - After edge 14: b_out=0, a_out=c_out=1, fault_active=1, fault_count=1.
  - After edge 15: all lanes =1, busy=0.
- Stuck-at-1 on lane a with data_in=0, inject at edge 20:
  - After edge 24: a_out=1 and stays 1 for 10 cycles.
  - Inject at edge 35 → a_out=0 after edge 35.
- Ignored injects: inject with fault_lane=00 → no state change and fault_count unchanged; inject pulsed during ARM and during a flip FAULT → timing identical to the single-inject case.
- Reset at edge k+2 of an ARM sequence → busy=0 after edge k+2, no fault is ever applied, fault_count=0.
- src_sel=1 for 255 cycles with no faults → lanes are always equal, the sequence repeats with period 255, and 16 consecutive flip faults leave fault_count=15.
